// File: rtl/cmd_sequencer_pkg.sv
// Shared types and opcodes for the 8080 LCD command sequencer.
package cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_I  = 3'd1,
        SET    = 3'd2,
        SEND_I = 3'd3,
        SEND   = 3'd4,
        DONE   = 3'd5
    } update_t;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] PASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam int IDX_W = 6;

    function automatic logic [8:0] mk_word(input logic dcx, input logic [7:0] b);
        return {dcx, b};
    endfunction

endpackage

// File: rtl/cmd_sequencer_init_rom.sv
// Panel power-up table: index in, {dcx, byte} out, purely combinational.
module cmd_sequencer_init_rom
    import cmd_sequencer_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [8:0]       o_word
);

    // Table lookup; unused indices read back as a harmless NOP-like zero.
    always_comb begin
        o_word = 9'h000;
        case (i_idx)
            6'd0:    o_word = mk_word(1'b0, 8'h01);
            6'd1:    o_word = mk_word(1'b0, 8'h11);
            6'd2:    o_word = mk_word(1'b0, 8'h3A);
            6'd3:    o_word = mk_word(1'b1, 8'h55);
            6'd4:    o_word = mk_word(1'b0, 8'h36);
            6'd5:    o_word = mk_word(1'b1, 8'h48);
            6'd6:    o_word = mk_word(1'b0, 8'hB1);
            6'd7:    o_word = mk_word(1'b1, 8'h00);
            6'd8:    o_word = mk_word(1'b1, 8'h1B);
            6'd9:    o_word = mk_word(1'b0, 8'hC0);
            6'd10:   o_word = mk_word(1'b1, 8'h23);
            6'd11:   o_word = mk_word(1'b0, 8'hC1);
            6'd12:   o_word = mk_word(1'b1, 8'h10);
            6'd13:   o_word = mk_word(1'b0, 8'h13);
            6'd14:   o_word = mk_word(1'b0, 8'h20);
            6'd15:   o_word = mk_word(1'b0, 8'h29);
            default: o_word = 9'h000;
        endcase
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Emits the init table or a full-window update (CASET/PASET/RAMWR + pixels)
// one byte per wr pulse on an 8080 bus.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int INIT_LEN = 16,
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr,
    input  update_t     mode,
    input  logic [15:0] pixel_data,
    output logic        cmd_finished,
    output logic        pixel_req,
    output logic [7:0]  lcd_data,
    output logic        lcd_dcx,
    output logic        lcd_wrx,
    output logic        lcd_csx
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);
    localparam logic [15:0]      W_M1     = 16'(WIDTH - 1);
    localparam logic [15:0]      H_M1     = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {
        U_CASET, U_CPARAM, U_PASET, U_PPARAM, U_RAMWR, U_PIX_HI, U_PIX_LO
    } ustate_t;

    ustate_t           r_ustate, w_ustate_nxt;
    logic [1:0]        r_pcnt, w_pcnt_nxt;
    logic [PIX_W-1:0]  r_pixcnt, w_pixcnt_nxt;
    logic [IDX_W-1:0]  r_init_idx, w_init_idx_nxt;
    logic [8:0]        w_rom_word, w_upd_word, w_word;
    logic [7:0]        w_param;
    logic              w_init_mode, w_upd_mode, w_emit;

    cmd_sequencer_init_rom u_rom (
        .i_idx  (r_init_idx),
        .o_word (w_rom_word)
    );

    assign w_init_mode = (mode == SEND_I) || (mode == SET_I);
    assign w_upd_mode  = (mode == SEND)   || (mode == SET);
    assign w_emit      = wr && ((mode == SEND_I) || (mode == SEND));

    // Word currently pointed at by the update FSM.
    always_comb begin
        w_param = 8'h00;
        case (r_pcnt)
            2'd2:    w_param = (r_ustate == U_CPARAM) ? W_M1[15:8] : H_M1[15:8];
            2'd3:    w_param = (r_ustate == U_CPARAM) ? W_M1[7:0]  : H_M1[7:0];
            default: w_param = 8'h00;
        endcase
        w_upd_word = mk_word(1'b0, CASET);
        case (r_ustate)
            U_CASET:  w_upd_word = mk_word(1'b0, CASET);
            U_CPARAM: w_upd_word = mk_word(1'b1, w_param);
            U_PASET:  w_upd_word = mk_word(1'b0, PASET);
            U_PPARAM: w_upd_word = mk_word(1'b1, w_param);
            U_RAMWR:  w_upd_word = mk_word(1'b0, RAMWR);
            U_PIX_HI: w_upd_word = mk_word(1'b1, pixel_data[15:8]);
            U_PIX_LO: w_upd_word = mk_word(1'b1, pixel_data[7:0]);
            default:  w_upd_word = mk_word(1'b0, CASET);
        endcase
        w_word = w_init_mode ? w_rom_word : w_upd_word;
    end

    // Last-word flag, derived from pointer state of the active sequence.
    always_comb begin
        cmd_finished = 1'b0;
        if (w_init_mode) begin
            cmd_finished = (r_init_idx == IDX_LAST);
        end else if (w_upd_mode) begin
            cmd_finished = (r_ustate == U_PIX_LO) && (r_pixcnt == PIX_LAST);
        end else begin
            cmd_finished = 1'b0;
        end
    end

    // Pointer advance; IDLE/DONE rewinds both sequences for abort recovery.
    always_comb begin
        w_ustate_nxt   = r_ustate;
        w_pcnt_nxt     = r_pcnt;
        w_pixcnt_nxt   = r_pixcnt;
        w_init_idx_nxt = r_init_idx;
        if ((mode == DONE) || (mode == IDLE)) begin
            w_ustate_nxt   = U_CASET;
            w_pcnt_nxt     = 2'd0;
            w_pixcnt_nxt   = '0;
            w_init_idx_nxt = '0;
        end else if (w_emit && w_init_mode) begin
            w_init_idx_nxt = (r_init_idx == IDX_LAST) ? '0 : r_init_idx + 6'd1;
        end else if (w_emit && w_upd_mode) begin
            case (r_ustate)
                U_CASET:  begin w_ustate_nxt = U_CPARAM; w_pcnt_nxt = 2'd0; end
                U_CPARAM: begin
                    w_pcnt_nxt = r_pcnt + 2'd1;
                    if (r_pcnt == 2'd3) w_ustate_nxt = U_PASET;
                    else                w_ustate_nxt = U_CPARAM;
                end
                U_PASET:  begin w_ustate_nxt = U_PPARAM; w_pcnt_nxt = 2'd0; end
                U_PPARAM: begin
                    w_pcnt_nxt = r_pcnt + 2'd1;
                    if (r_pcnt == 2'd3) w_ustate_nxt = U_RAMWR;
                    else                w_ustate_nxt = U_PPARAM;
                end
                U_RAMWR:  w_ustate_nxt = U_PIX_HI;
                U_PIX_HI: w_ustate_nxt = U_PIX_LO;
                U_PIX_LO: begin
                    if (r_pixcnt == PIX_LAST) begin
                        w_ustate_nxt = U_CASET;
                        w_pixcnt_nxt = '0;
                    end else begin
                        w_ustate_nxt = U_PIX_HI;
                        w_pixcnt_nxt = r_pixcnt + PIX_W'(1);
                    end
                end
                default:  w_ustate_nxt = U_CASET;
            endcase
        end else begin
            w_ustate_nxt = r_ustate;
        end
    end

    // State registers and registered bus outputs; wrx low for the single cycle after wr.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_ustate   <= U_CASET;
            r_pcnt     <= 2'd0;
            r_pixcnt   <= '0;
            r_init_idx <= '0;
            lcd_wrx    <= 1'b1;
            lcd_csx    <= 1'b1;
            lcd_dcx    <= 1'b0;
            lcd_data   <= 8'h00;
            pixel_req  <= 1'b0;
        end else begin
            r_ustate   <= w_ustate_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_pixcnt   <= w_pixcnt_nxt;
            r_init_idx <= w_init_idx_nxt;
            lcd_wrx    <= ~w_emit;
            lcd_csx    <= (mode == IDLE);
            pixel_req  <= w_emit && w_upd_mode && (r_ustate == U_PIX_LO);
            if (w_emit) begin
                lcd_dcx  <= w_word[8];
                lcd_data <= w_word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench: stimulus queues expected {pixel_req,dcx,byte}; a negedge monitor checks each wrx pulse.
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        wr;
    update_t     mode;
    logic [15:0] pixel_data;
    logic        cmd_finished, pixel_req, lcd_dcx, lcd_wrx, lcd_csx;
    logic [7:0]  lcd_data;

    int errors = 0;
    int checks = 0;
    int pixreq_cnt = 0;
    logic [9:0] exp_q[$];

    logic [8:0]  rom_exp [16] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h0B1, 9'h100,
                                  9'h11B, 9'h0C0, 9'h123, 9'h0C1, 9'h110, 9'h013, 9'h020, 9'h029};
    logic [7:0]  upd_bytes [19] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h01,
                                    8'h2C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [15:0] pix_vec [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    cmd_sequencer #(.INIT_LEN(16), .WIDTH(2), .HEIGHT(2)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .wr           (wr),
        .mode         (mode),
        .pixel_data   (pixel_data),
        .cmd_finished (cmd_finished),
        .pixel_req    (pixel_req),
        .lcd_data     (lcd_data),
        .lcd_dcx      (lcd_dcx),
        .lcd_wrx      (lcd_wrx),
        .lcd_csx      (lcd_csx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every wrx-low cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        if (pixel_req === 1'b1) pixreq_cnt++;
        if (lcd_wrx === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wrx", {22'd0, pixel_req, lcd_dcx, lcd_data}, 32'hFFFF_FFFF);
            end else begin
                chk("emitted_word", {22'd0, pixel_req, lcd_dcx, lcd_data}, {22'd0, exp_q.pop_front()});
            end
        end else if (pixel_req === 1'b1) begin
            chk("pixel_req_without_wrx", 32'd1, 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic exp_fin, input string nm);
        wr = 1'b1;
        #1;
        chk(nm, {31'd0, cmd_finished}, {31'd0, exp_fin});
        @(posedge clk);
        #1;
        wr = 1'b0;
        cyc();
    endtask

    task automatic push_rom(input int i);
        exp_q.push_back({1'b0, rom_exp[i]});
    endtask

    task automatic upd_word(input int k);
        logic dcx;
        logic preq;
        dcx  = !(k == 0 || k == 5 || k == 10);
        preq = (k >= 12) && (k % 2 == 0);
        if (k >= 11) pixel_data = pix_vec[(k - 11) / 2];
        exp_q.push_back({preq, dcx, upd_bytes[k]});
        do_wr(k == 18, "upd_finished");
    endtask

    initial begin
        nrst = 1'b1; wr = 1'b0; mode = IDLE; pixel_data = 16'h0000;
        repeat (3) cyc();
        nrst = 1'b0;
        repeat (5) cyc();
        chk("idle_wrx", {31'd0, lcd_wrx}, 32'd1);
        chk("idle_csx", {31'd0, lcd_csx}, 32'd1);
        chk("idle_data", {24'd0, lcd_data}, 32'h00);
        chk("idle_dcx", {31'd0, lcd_dcx}, 32'd0);
        chk("idle_finished", {31'd0, cmd_finished}, 32'd0);

        // Full init sequence, then wrap back to index 0.
        mode = SEND_I;
        cyc();
        chk("csx_active", {31'd0, lcd_csx}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            push_rom(i);
            do_wr(i == 15, "init_finished");
        end
        push_rom(0);
        do_wr(1'b0, "init_wrap_finished");

        // wr outside SEND_I/SEND is ignored and the pointer holds.
        mode = SET_I;
        do_wr(1'b0, "set_i_finished");
        mode = SEND_I;
        push_rom(1);
        do_wr(1'b0, "init_hold_finished");
        mode = IDLE;
        do_wr(1'b0, "idle_wr_finished");
        chk("csx_idle_again", {31'd0, lcd_csx}, 32'd1);
        mode = SEND_I;
        push_rom(0);
        do_wr(1'b0, "init_after_idle");

        // Full 2x2 update, then wrap to CASET.
        mode = SEND;
        for (int k = 0; k < 19; k++) upd_word(k);
        exp_q.push_back({2'b00, 8'h2A});
        do_wr(1'b0, "upd_wrap_finished");

        // Abort after 7 words with a SET no-op in the middle, then restart.
        mode = DONE;
        cyc();
        chk("done_finished", {31'd0, cmd_finished}, 32'd0);
        mode = SEND;
        for (int k = 0; k < 3; k++) upd_word(k);
        mode = SET;
        do_wr(1'b0, "set_wr_finished");
        mode = SEND;
        for (int k = 3; k < 7; k++) upd_word(k);
        mode = DONE;
        cyc();
        mode = SEND;
        exp_q.push_back({2'b00, 8'h2A});
        do_wr(1'b0, "restart_finished");

        // Reset while wrx is low.
        mode = IDLE;
        cyc();
        mode = SEND_I;
        push_rom(0); do_wr(1'b0, "pre_rst_0");
        push_rom(1); do_wr(1'b0, "pre_rst_1");
        push_rom(2);
        wr = 1'b1;
        cyc();
        wr = 1'b0;
        nrst = 1'b1;
        chk("wrx_low_at_rst", {31'd0, lcd_wrx}, 32'd0);
        cyc();
        chk("rst_wrx", {31'd0, lcd_wrx}, 32'd1);
        chk("rst_data", {24'd0, lcd_data}, 32'h00);
        chk("rst_csx", {31'd0, lcd_csx}, 32'd1);
        nrst = 1'b0;
        cyc();
        chk("post_rst_wrx", {31'd0, lcd_wrx}, 32'd1);
        push_rom(0);
        do_wr(1'b0, "post_rst_finished");

        repeat (3) cyc();
        chk("pixel_req_count", pixreq_cnt, 32'd4);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
